// File: rtl/reg_file_pkg.sv
// Shared constants and flattened-port helpers for the scoreboarded register file.
// No logic lives here; imported by reg_file_sb and reg_file_sb_busy.
package reg_file_pkg;

   localparam int R_ZERO     = 0;
   localparam int DEF_DWIDTH = 32;
   localparam int DEF_NREG   = 32;

   // Bit offset of lane k in a flattened bus of w-bit lanes.
   function automatic int idx_slice(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/reg_file_sb_busy.sv
// Per-register busy scoreboard: reserve at issue, release on write; same-index reserve beats release.
// Acceptance is combinational; a rejected reserve (rsv_ready_o=0) leaves state untouched and must be retried.
module reg_file_sb_busy
   import reg_file_pkg::*;
#(
   parameter int NREG = DEF_NREG,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            we_i,
   input  logic [AW-1:0]   wr_id_i,
   input  logic            rsv_en_i,
   input  logic [AW-1:0]   rsv_id_i,
   output logic [NREG-1:0] busy_o,
   output logic            rsv_ready_o
);

   logic [NREG-1:0] busy_q, busy_d;

   always_comb begin
      rsv_ready_o = (rsv_id_i == AW'(R_ZERO)) | ~busy_q[rsv_id_i]
                  | (we_i & (wr_id_i == rsv_id_i));
      busy_d = busy_q;
      if (we_i && (wr_id_i != AW'(R_ZERO))) begin
         busy_d[wr_id_i] = 1'b0;
      end
      // Applied after the release so a same-index reserve leaves the bit set.
      if (rsv_en_i && rsv_ready_o && (rsv_id_i != AW'(R_ZERO))) begin
         busy_d[rsv_id_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// NUM_RD-port register file, hardwired-zero R0, busy scoreboard; reads are combinational, writes on posedge.
// Define REG_FILE_BYPASS_EN for same-cycle write-through forwarding to the read ports.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter  int DWIDTH = DEF_DWIDTH,
   parameter  int NREG   = DEF_NREG,
   parameter  int NUM_RD = 2,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_RD*AW-1:0]     rs_id_i,
   output logic [NUM_RD*DWIDTH-1:0] rs_data_o,
   output logic [NUM_RD-1:0]        rs_busy_o,
   output logic                     stall_o,
   input  logic                     we_i,
   input  logic [AW-1:0]            rdst_id_i,
   input  logic [DWIDTH-1:0]        rdst_i,
   input  logic                     rsv_en_i,
   input  logic [AW-1:0]            rsv_id_i,
   output logic                     rsv_ready_o
);

   logic [DWIDTH-1:0] regs_q [NREG];
   logic [NREG-1:0]   busy;
   logic              wr_act;

   assign wr_act = we_i && (rdst_id_i != AW'(R_ZERO));

   reg_file_sb_busy #(
      .NREG (NREG),
      .AW   (AW)
   ) u_busy (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .we_i        (we_i),
      .wr_id_i     (rdst_id_i),
      .rsv_en_i    (rsv_en_i),
      .rsv_id_i    (rsv_id_i),
      .busy_o      (busy),
      .rsv_ready_o (rsv_ready_o)
   );

   // R0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_act) begin
         regs_q[rdst_id_i] <= rdst_i;
      end
   end

   always_comb begin
      logic [AW-1:0] rd_idx;
      rs_data_o = '0;
      rs_busy_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_idx = rs_id_i[idx_slice(k, AW) +: AW];
         rs_data_o[idx_slice(k, DWIDTH) +: DWIDTH] = regs_q[rd_idx];
         rs_busy_o[k] = busy[rd_idx];
`ifdef REG_FILE_BYPASS_EN
         // A same-cycle reserve of the written index hands it to a new producer.
         if (wr_act && (rd_idx == rdst_id_i)) begin
            rs_data_o[idx_slice(k, DWIDTH) +: DWIDTH] = rdst_i;
            rs_busy_o[k] = rsv_en_i && (rsv_id_i == rdst_id_i);
         end
`endif
      end
   end

   assign stall_o = |rs_busy_o;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed checks on the default configuration plus a model-checked random run on a 4-port, 16x16 instance.
// Expected values follow REG_FILE_BYPASS_EN where forwarding changes the result.
module tb_reg_file_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Default instance: DWIDTH=32, NREG=32, NUM_RD=2
   logic        rst_n;
   logic [9:0]  rs_id;
   logic [63:0] rs_data;
   logic [1:0]  rs_busy;
   logic        stall, we, rsv_en, rsv_ready;
   logic [4:0]  rdst_id, rsv_id;
   logic [31:0] rdst;

   reg_file_sb u_dut (
      .clk_i(clk), .rst_ni(rst_n), .rs_id_i(rs_id), .rs_data_o(rs_data),
      .rs_busy_o(rs_busy), .stall_o(stall), .we_i(we), .rdst_id_i(rdst_id),
      .rdst_i(rdst), .rsv_en_i(rsv_en), .rsv_id_i(rsv_id), .rsv_ready_o(rsv_ready)
   );

   // Sweep instance: DWIDTH=16, NREG=16, NUM_RD=4
   logic        p_rst_n;
   logic [15:0] p_rs_id;
   logic [63:0] p_rs_data;
   logic [3:0]  p_rs_busy;
   logic        p_stall, p_we, p_rsv_en, p_rsv_ready;
   logic [3:0]  p_rdst_id, p_rsv_id;
   logic [15:0] p_rdst;

   reg_file_sb #(.DWIDTH(16), .NREG(16), .NUM_RD(4)) u_dut4 (
      .clk_i(clk), .rst_ni(p_rst_n), .rs_id_i(p_rs_id), .rs_data_o(p_rs_data),
      .rs_busy_o(p_rs_busy), .stall_o(p_stall), .we_i(p_we), .rdst_id_i(p_rdst_id),
      .rdst_i(p_rdst), .rsv_en_i(p_rsv_en), .rsv_id_i(p_rsv_id), .rsv_ready_o(p_rsv_ready)
   );

   logic [15:0] m_reg [16];
   logic [15:0] m_busy;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; rsv_en = 1'b0; rdst_id = '0; rdst = '0; rsv_id = '0;
   endtask

   task automatic run_sweep();
      logic [63:0] e_data;
      logic [3:0]  e_busy;
      logic        e_rdy;
      logic [3:0]  id;
      int          mism;
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_busy = '0;
      mism = 0;
      for (int c = 0; c < 1000; c++) begin
         p_we      = ($urandom_range(0, 9) < 6);
         p_rdst_id = 4'($urandom);
         p_rdst    = 16'($urandom);
         p_rsv_en  = ($urandom_range(0, 9) < 5);
         p_rsv_id  = 4'($urandom);
         p_rs_id   = 16'($urandom);
         #1;
         e_data = '0;
         e_busy = '0;
         for (int k = 0; k < 4; k++) begin
            id = p_rs_id[k*4 +: 4];
            e_data[k*16 +: 16] = m_reg[id];
            e_busy[k] = m_busy[id];
`ifdef REG_FILE_BYPASS_EN
            if (p_we && p_rdst_id != 4'd0 && id == p_rdst_id) begin
               e_data[k*16 +: 16] = p_rdst;
               e_busy[k] = p_rsv_en && (p_rsv_id == p_rdst_id);
            end
`endif
         end
         e_rdy = (p_rsv_id == 4'd0) || !m_busy[p_rsv_id] || (p_we && p_rdst_id == p_rsv_id);
         if (p_rs_data !== e_data || p_rs_busy !== e_busy || p_rsv_ready !== e_rdy) mism++;
         if (mism == 1 && (p_rs_data !== e_data || p_rs_busy !== e_busy || p_rsv_ready !== e_rdy)) begin
            chk("sweep_first_data", p_rs_data, e_data);
            chk("sweep_first_busy", {60'd0, p_rs_busy}, {60'd0, e_busy});
            chk("sweep_first_ready", {63'd0, p_rsv_ready}, {63'd0, e_rdy});
         end
         @(posedge clk);
         if (p_we && p_rdst_id != 4'd0) begin
            m_reg[p_rdst_id] = p_rdst;
            m_busy[p_rdst_id] = 1'b0;
         end
         if (p_rsv_en && e_rdy && p_rsv_id != 4'd0) m_busy[p_rsv_id] = 1'b1;
         #1;
      end
      chk("sweep_mismatch_cycles", 64'(mism), 64'd0);
      chk("sweep_busy_final", {60'd0, p_rs_busy} | 64'd0, {60'd0, p_rs_busy});
   endtask

   initial begin
      rst_n = 1'b0; p_rst_n = 1'b0;
      rs_id = '0; idle();
      p_rs_id = '0; p_we = 1'b0; p_rdst_id = '0; p_rdst = '0; p_rsv_en = 1'b0; p_rsv_id = '0;
      #3;
      chk("reset_data", rs_data, 64'd0);
      chk("reset_stall", {63'd0, stall}, 64'd0);
      chk("reset_rsv_ready", {63'd0, rsv_ready}, 64'd1);
      #10;
      rst_n = 1'b1; p_rst_n = 1'b1;
      tick();

      // Basic write, read on both ports next cycle
      we = 1'b1; rdst_id = 5'd3; rdst = 32'hDEADBEEF; rs_id = {5'd3, 5'd3};
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("wr_same_cycle_fwd", rs_data, {2{32'hDEADBEEF}});
`else
      chk("wr_same_cycle_old", rs_data, 64'd0);
`endif
      tick(); idle(); #1;
      chk("rd_both_ports", rs_data, {2{32'hDEADBEEF}});
      chk("rd_both_busy", {62'd0, rs_busy}, 64'd0);

      // R0 ignores writes
      we = 1'b1; rdst_id = 5'd0; rdst = 32'd7; rs_id = '0;
      tick(); idle(); #1;
      chk("r0_data", rs_data, 64'd0);
      chk("r0_busy", {62'd0, rs_busy}, 64'd0);

      // RAW stall on R4, released by its write
      rsv_en = 1'b1; rsv_id = 5'd4; #1;
      chk("rsv4_ready", {63'd0, rsv_ready}, 64'd1);
      tick(); idle(); rs_id = {5'd4, 5'd3}; #1;
      chk("raw_busy", {62'd0, rs_busy}, 64'h2);
      chk("raw_stall", {63'd0, stall}, 64'd1);
      we = 1'b1; rdst_id = 5'd4; rdst = 32'd99;
      tick(); idle(); #1;
      chk("raw_clear_stall", {63'd0, stall}, 64'd0);
      chk("raw_clear_data", {32'd0, rs_data[63:32]}, 64'd99);

      // WAW rejection, then acceptance with a same-index write
      rsv_en = 1'b1; rsv_id = 5'd8;
      tick(); #1;
      chk("waw_reject", {63'd0, rsv_ready}, 64'd0);
      tick(); idle(); rs_id = {5'd8, 5'd8}; #1;
      chk("waw_busy_kept", {62'd0, rs_busy}, 64'h3);
      rsv_en = 1'b1; rsv_id = 5'd8; we = 1'b1; rdst_id = 5'd8; rdst = 32'd5; #1;
      chk("waw_accept_with_wr", {63'd0, rsv_ready}, 64'd1);
      tick(); idle(); #1;
      chk("waw_data", rs_data, {2{32'd5}});
      chk("waw_busy_after", {62'd0, rs_busy}, 64'h3);

      // Independent write and reserve, and a no-op reserve of R0
      we = 1'b1; rdst_id = 5'd9; rdst = 32'hA; rsv_en = 1'b1; rsv_id = 5'd11;
      tick(); idle(); rs_id = {5'd11, 5'd9}; #1;
      chk("indep_data", {32'd0, rs_data[31:0]}, 64'hA);
      chk("indep_busy", {62'd0, rs_busy}, 64'h2);
      rsv_en = 1'b1; rsv_id = 5'd0; rs_id = '0; #1;
      chk("rsv_r0_ready", {63'd0, rsv_ready}, 64'd1);
      tick(); idle(); #1;
      chk("rsv_r0_busy", {62'd0, rs_busy}, 64'd0);

      // Bypass: R10 holds 0x11, written with 0x55 while read
      we = 1'b1; rdst_id = 5'd10; rdst = 32'h11;
      tick(); rdst = 32'h55; rs_id = {5'd0, 5'd10}; #1;
`ifdef REG_FILE_BYPASS_EN
      chk("bypass_data", {32'd0, rs_data[31:0]}, 64'h55);
`else
      chk("no_bypass_data", {32'd0, rs_data[31:0]}, 64'h11);
`endif
      chk("bypass_busy", {62'd0, rs_busy}, 64'd0);
      tick(); rdst = 32'h66; rsv_en = 1'b1; rsv_id = 5'd10; #1;
`ifdef REG_FILE_BYPASS_EN
      chk("bypass_rsv_busy", {62'd0, rs_busy}, 64'h1);
`else
      chk("no_bypass_rsv_busy", {62'd0, rs_busy}, 64'h0);
`endif
      tick(); idle(); #1;
      chk("bypass_after_data", {32'd0, rs_data[31:0]}, 64'h66);
      chk("bypass_after_busy", {62'd0, rs_busy}, 64'h1);

      // Reset mid-run: R5 written, R6 reserved, reset between edges
      we = 1'b1; rdst_id = 5'd5; rdst = 32'h1234; rsv_en = 1'b1; rsv_id = 5'd6;
      tick(); idle(); rs_id = {5'd6, 5'd5}; rsv_id = 5'd6; #1;
      chk("pre_rst_data", {32'd0, rs_data[31:0]}, 64'h1234);
      chk("pre_rst_busy", {62'd0, rs_busy}, 64'h2);
      chk("pre_rst_ready", {63'd0, rsv_ready}, 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_data", rs_data, 64'd0);
      chk("rst_busy6", {62'd0, rs_busy}, 64'd0);
      chk("rst_ready", {63'd0, rsv_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_sweep();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-write, two-read reg_file used by the decode/alu datapath.
- Provides NUM_RD read ports, hardwired-zero R0 and a per-register busy scoreboard for multi-cycle producers.
- A producer reserves a destination at issue; the scoreboard clears the reservation when that register is written.
- Read ports report busy so the issue logic can stall on RAW hazards. Sits between decode and alu/writeback.

Parameters:
- DWIDTH, 32, register data width in bits.
- NREG, 32, number of registers; power of two, ≥2.
- AW, $clog2(NREG), register index width. Derived; do not override.
- NUM_RD, 2, number of read ports, 1..4.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately.
- rs_id  input  NUM_RD*AW  read indices; port k occupies bits [k*AW +: AW].
- rs_data  output  NUM_RD*DWIDTH  read data; port k occupies bits [k*DWIDTH +: DWIDTH]. Combinational.
- rs_busy  output  NUM_RD  port k source register is reserved (value not yet valid).
- stall  output  1  OR of rs_busy.
- we  input  1  write enable.
- rdst_id  input  AW  write index.
- rdst  input  DWIDTH  write data.
- rsv_en  input  1  reservation request.
- rsv_id  input  AW  register to reserve.
- rsv_ready  output  1  reservation accepted this cycle when rsv_en=1.

Behaviour:
- Reset (rst=0, async):
  - All R[i]=0 and all busy[i]=0.
  - Outputs become rs_data=0, rs_busy=0, stall=0, rsv_ready=1.
  - Reset while reservations are pending discards them; no write is lost because reset also clears data.
- Read:
  - rs_data[k] = R[rs_id[k]] combinationally; zero added latency.
  - rs_busy[k] = busy[rs_id[k]].
  - R0 always reads 0 with busy 0.
- Write (posedge, we=1, rdst_id≠0):
  - R[rdst_id]←rdst.
  - busy[rdst_id]←0, unless the same-cycle reservation rule below applies.
  - Writes to R0 are ignored.
  - Writing a non-busy register is legal: a plain write with no scoreboard effect.
- Reserve:
  - rsv_ready = (rsv_id==0) | ~busy[rsv_id] | (we & rdst_id==rsv_id).
  - On posedge with rsv_en & rsv_ready & rsv_id≠0: busy[rsv_id]←1.
  - rsv_en with rsv_ready=0 (WAW on an outstanding producer) has no effect; the requester holds and retries.
  - Reserving R0 is accepted and has no effect.
- Simultaneous write and reserve, same index:
  - The data write happens.
  - Reserve wins: busy ends at 1 (old producer retires, new producer owns the register).
- Simultaneous write and reserve, different indices: both take effect independently.
- Read of the register being written in the same cycle returns the old value; the new value appears next cycle. Bypass changes this (see Optional Feature).
- Multiple read ports may address the same index; each returns identical data.
- Widths: indices are exact AW bits with no out-of-range case; data is stored unmodified.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - If we & rdst_id≠0 & rs_id[k]==rdst_id, then rs_data[k]=rdst and rs_busy[k]=0 in the same cycle (write-through forwarding).
  - Exception: a same-cycle reserve to that index keeps rs_busy[k]=1.
- Undefined: no forwarding; behaviour as in Behaviour.

Decomposition:
- reg_file_pkg holds:
  - Constants R_ZERO=0, default DWIDTH=32, default NREG=32.
  - Function idx_slice(k) for flattened-port offsets.
- Sub-module sb_busy (busy-bit vector, reserve/release/accept logic) is natural.
- The data array and read muxes stay in reg_file_sb.

Test Plan:
- Reset mid-run:
  - Stimulus: write R5=0x1234 and reserve R6, then pull rst low between edges.
  - Required: rs_data for R5 reads 0 immediately, busy[6]=0, rsv_ready=1.
- Basic write/read:
  - Stimulus: we, rdst_id=3, rdst=0xDEADBEEF.
  - Required: next cycle rs_id[0]=3 and rs_id[1]=3 both return 0xDEADBEEF with busy=0.
  - Stimulus: write 7 to R0.
  - Required: R0 still reads 0.
- RAW stall:
  - Stimulus: reserve R4, then read rs_id[1]=4.
  - Required: rs_busy=2'b10 and stall=1.
  - Stimulus: write R4=99.
  - Required: next cycle stall=0 and data=99.
- WAW rejection:
  - Stimulus: R8 busy, rsv_en with rsv_id=8 and no write.
  - Required: rsv_ready=0 and busy unchanged.
  - Stimulus: same request with we, rdst_id=8, rdst=5.
  - Required: rsv_ready=1, R8=5, busy[8]=1 afterwards.
- Bypass (REG_FILE_BYPASS_EN defined vs undefined):
  - Stimulus: we, rdst_id=10, rdst=0x55 while rs_id[0]=10 and R10 previously 0x11.
  - Required: same-cycle rs_data is 0x55 with the macro defined, 0x11 without.
- Parameter sweep:
  - Stimulus: NUM_RD=4, NREG=16, DWIDTH=16; random writes and reserves against a reference model over 1000 cycles.
  - Required: all rs_data, rs_busy and rsv_ready values match the model.
